apb_gpio_banked: RTL



---
 rtl/apb_gpio_banked_pkg.sv | 45 ++++
 rtl/apb_gpio_banked_if.sv | 25 ++
 rtl/apb_gpio_banked_input.sv | 92 +++++++++
 rtl/apb_gpio_banked.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_banked_pkg.sv
// Shared constants, register offsets and helpers for the banked APB GPIO.
// Each bank is 32 pins and occupies a 0x40-byte register window.
package apb_gpio_banked_pkg;

    localparam int BANK_W      = 32;
    localparam int BANK_STRIDE = 'h40;

    localparam logic [5:0] OFF_DIR        = 6'h00;
    localparam logic [5:0] OFF_IN         = 6'h04;
    localparam logic [5:0] OFF_OUT        = 6'h08;
    localparam logic [5:0] OFF_OUTSET     = 6'h0C;
    localparam logic [5:0] OFF_OUTCLR     = 6'h10;
    localparam logic [5:0] OFF_INTEN      = 6'h14;
    localparam logic [5:0] OFF_INTTYPE_LO = 6'h18;
    localparam logic [5:0] OFF_INTTYPE_HI = 6'h1C;
    localparam logic [5:0] OFF_INTSTATUS  = 6'h20;
    localparam logic [5:0] OFF_FILTEN     = 6'h24;
    localparam logic [5:0] OFF_LAST       = OFF_FILTEN;

    typedef enum logic [1:0] {
        RISE       = 2'b00,
        FALL       = 2'b01,
        BOTH       = 2'b10,
        LEVEL_HIGH = 2'b11
    } int_type_e;

    // Bits of a bank that map to real pads; pins past pad_num stay at 0.
    function automatic logic [BANK_W-1:0] pin_mask(input int bank, input int pad_num);
        logic [BANK_W-1:0] m;
        for (int i = 0; i < BANK_W; i++) begin
            m[i] = ((bank * BANK_W + i) < pad_num);
        end
        return m;
    endfunction

    // Widen a 16-pin mask to the 2-bits-per-pin layout of INTTYPE_LO/HI.
    function automatic logic [31:0] type_mask(input logic [15:0] pins);
        logic [31:0] m;
        for (int i = 0; i < 16; i++) begin
            m[2*i +: 2] = {2{pins[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/apb_gpio_banked_if.sv
// APB3 slave port of the banked GPIO.
// Handshake: a transfer is setup (PSEL=1, PENABLE=0) followed by access (PSEL=1,
// PENABLE=1); the slave completes in the access cycle when PREADY=1 (always here).
interface apb_gpio_banked_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_gpio_banked_input.sv
// Input path of one 32-pin bank: synchroniser, glitch filter, prev register
// and per-pin event generation according to the configured interrupt type.
module gpio_bank_input
    import apb_gpio_banked_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BANK_W-1:0]   pad,
    input  logic [BANK_W-1:0]   filt_en,
    input  logic [2*BANK_W-1:0] int_type,
    input  logic                priming,
    output logic [BANK_W-1:0]   sync,
    output logic [BANK_W-1:0]   filt,
    output logic [BANK_W-1:0]   evt
);

    localparam int CNT_W = (FILT_DEPTH > 1) ? $clog2(FILT_DEPTH) : 1;

    logic [SYNC_STAGES-1:0][BANK_W-1:0] sync_q;
    logic [BANK_W-1:0]                  filt_q;
    logic [BANK_W-1:0]                  prev_q;
    logic [BANK_W-1:0][CNT_W-1:0]       cnt_q;
    logic [BANK_W-1:0]                  rise;
    logic [BANK_W-1:0]                  fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pad;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // The counter counts samples that disagree with the filtered value; the
    // FILT_DEPTH-th consecutive disagreeing sample commits the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < BANK_W; i++) begin
                if (!filt_en[i] || (sync[i] == filt_q[i])) begin
                    filt_q[i] <= sync[i];
                    cnt_q[i]  <= '0;
                end else if (cnt_q[i] == CNT_W'(FILT_DEPTH - 1)) begin
                    filt_q[i] <= sync[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign filt = (filt_en & filt_q) | (~filt_en & sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= filt;
        end
    end

    assign rise = filt & ~prev_q;
    assign fall = ~filt & prev_q;

    always_comb begin
        evt = '0;
        for (int i = 0; i < BANK_W; i++) begin
            case (int_type_e'(int_type[2*i +: 2]))
                RISE:       evt[i] = rise[i];
                FALL:       evt[i] = fall[i];
                BOTH:       evt[i] = rise[i] | fall[i];
                LEVEL_HIGH: evt[i] = filt[i];
                default:    evt[i] = 1'b0;
            endcase
        end
        if (priming) begin
            evt = '0;
        end
    end

endmodule

// File: rtl/apb_gpio_banked.sv
// Banked APB GPIO controller: APB decode, per-bank register file, post-reset
// priming counter and the registered interrupt output.
module apb_gpio_banked
    import apb_gpio_banked_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int PAD_NUM        = 64,
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_DEPTH     = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    apb_gpio_banked_if.slave    apb,
    input  logic [PAD_NUM-1:0]  gpio_in_i,
    output logic [PAD_NUM-1:0]  gpio_in_sync_o,
    output logic [PAD_NUM-1:0]  gpio_out_o,
    output logic [PAD_NUM-1:0]  gpio_oe_o,
    output logic                interrupt_o
);

    localparam int NBANK     = (PAD_NUM + BANK_W - 1) / BANK_W;
    localparam int NPIN      = NBANK * BANK_W;
    localparam int OFF_W     = $clog2(BANK_STRIDE);
    localparam int BIDX_W    = APB_ADDR_WIDTH - OFF_W;
    localparam int PRIME_CYC = SYNC_STAGES + FILT_DEPTH;
    localparam int PCNT_W    = $clog2(PRIME_CYC + 1);

    logic [NBANK-1:0][BANK_W-1:0]   dir_q, out_q, inten_q, status_q, filten_q;
    logic [NBANK-1:0][2*BANK_W-1:0] type_q;
    logic [NBANK-1:0][BANK_W-1:0]   filt_v, evt_v, valid_m, status_clr;
    logic [NPIN-1:0]                pad_ext, sync_flat, out_flat, dir_flat;

    logic [BIDX_W-1:0] bank_idx;
    logic [OFF_W-1:0]  off;
    logic [5:0]        reg_off;
    logic              bad_acc, wr_en;
    logic [31:0]       rdata;
    logic [PCNT_W-1:0] pcnt_q;
    logic              priming;

    assign pad_ext  = NPIN'(gpio_in_i);
    assign out_flat = out_q;
    assign dir_flat = dir_q;

    assign gpio_in_sync_o = sync_flat[PAD_NUM-1:0];
    assign gpio_out_o     = out_flat[PAD_NUM-1:0];
    assign gpio_oe_o      = dir_flat[PAD_NUM-1:0];

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        assign valid_m[b] = pin_mask(b, PAD_NUM);

        gpio_bank_input #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_DEPTH  (FILT_DEPTH)
        ) u_input (
            .clk      (clk_i),
            .rst_n    (rst_ni),
            .pad      (pad_ext[b*BANK_W +: BANK_W]),
            .filt_en  (filten_q[b]),
            .int_type (type_q[b]),
            .priming  (priming),
            .sync     (sync_flat[b*BANK_W +: BANK_W]),
            .filt     (filt_v[b]),
            .evt      (evt_v[b])
        );
    end

    assign bank_idx = apb.PADDR[APB_ADDR_WIDTH-1:OFF_W];
    assign off      = apb.PADDR[OFF_W-1:0];
    assign reg_off  = {off[5:2], 2'b00};
    assign bad_acc  = (int'(bank_idx) >= NBANK) || (off > OFF_LAST);
    assign wr_en    = apb.PSEL && apb.PENABLE && apb.PWRITE && !bad_acc;

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL && apb.PENABLE && bad_acc;
    assign apb.PRDATA  = rdata;

    always_comb begin
        rdata = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (bank_idx == BIDX_W'(b)) begin
                case (reg_off)
                    OFF_DIR:        rdata = dir_q[b];
                    OFF_IN:         rdata = filt_v[b] & valid_m[b];
                    OFF_OUT:        rdata = out_q[b];
                    OFF_INTEN:      rdata = inten_q[b];
                    OFF_INTTYPE_LO: rdata = type_q[b][31:0];
                    OFF_INTTYPE_HI: rdata = type_q[b][63:32];
                    OFF_INTSTATUS:  rdata = status_q[b];
                    OFF_FILTEN:     rdata = filten_q[b];
                    default:        rdata = '0;
                endcase
            end
        end
        if (bad_acc) begin
            rdata = '0;
        end
    end

    // Writes are masked so bits of pins beyond PAD_NUM never become 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q    <= '0;
            out_q    <= '0;
            inten_q  <= '0;
            type_q   <= '0;
            filten_q <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < NBANK; b++) begin
                if (bank_idx == BIDX_W'(b)) begin
                    case (reg_off)
                        OFF_DIR:        dir_q[b]         <= apb.PWDATA & valid_m[b];
                        OFF_OUT:        out_q[b]         <= apb.PWDATA & valid_m[b];
                        OFF_OUTSET:     out_q[b]         <= out_q[b] | (apb.PWDATA & valid_m[b]);
                        OFF_OUTCLR:     out_q[b]         <= out_q[b] & ~apb.PWDATA;
                        OFF_INTEN:      inten_q[b]       <= apb.PWDATA & valid_m[b];
                        OFF_INTTYPE_LO: type_q[b][31:0]  <= apb.PWDATA & type_mask(valid_m[b][15:0]);
                        OFF_INTTYPE_HI: type_q[b][63:32] <= apb.PWDATA & type_mask(valid_m[b][31:16]);
                        OFF_FILTEN:     filten_q[b]      <= apb.PWDATA & valid_m[b];
                        default:        ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        status_clr = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (wr_en && (bank_idx == BIDX_W'(b)) && (reg_off == OFF_INTSTATUS)) begin
                status_clr[b] = apb.PWDATA;
            end
        end
    end

    // New events are OR-ed after the clear so a same-cycle event wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q <= '0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                status_q[b] <= ((status_q[b] & ~status_clr[b]) | evt_v[b]) & valid_m[b];
            end
        end
    end

    // Events are suppressed until the sync chain and filter hold real pad values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt_q <= '0;
        end else if (priming) begin
            pcnt_q <= pcnt_q + PCNT_W'(1);
        end
    end

    assign priming = (pcnt_q != PCNT_W'(PRIME_CYC));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            interrupt_o <= 1'b0;
        end else begin
            interrupt_o <= |(status_q & inten_q);
        end
    end

endmodule
